// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin arbiter that shares one UART transmitter between NREQ requesters.
// One requester is granted at a time. Its byte is latched onto tx_data, and
// send is held until the transmitter raises donetx. The winner then gets a
// one-cycle ack. If the transmitter never finishes, the winner gets a
// one-cycle err after TIMEOUT cycles instead.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   req       per-requester request level, held until ack/err
//   req_data  byte of requester i at [i*DW +: DW], sampled only at grant
//   ack       one-hot, one-cycle pulse: the frame completed
//   err       one-hot, one-cycle pulse: the frame timed out
//   gnt_id    index of the current or most recent grant
//   busy      high whenever the scheduler is not idle
//   send      start request to the transmitter, held for the whole frame
//   tx_data   byte presented to the transmitter
//   donetx    completion level from the transmitter (synchronous to clk)
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         err,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    send,
    output logic [DW-1:0]           tx_data,
    input  logic                    donetx
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic            donetx_q;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   pick_data;
    logic [IW:0]     cand;

    // Round-robin search starting at last+1 and wrapping modulo NREQ.
    // The loop runs from the farthest offset down to the nearest one. A later
    // match overwrites an earlier one, so the nearest requester after 'last'
    // wins. The extra bit in cand holds last+k before the wrap is applied.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, last} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (req[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        pick_data = req_data[int'(pick_idx)*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            send     <= 1'b0;
            tx_data  <= '0;
            ack      <= '0;
            err      <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            last     <= IW'(NREQ - 1);
            cnt      <= '0;
            donetx_q <= 1'b0;
        end else begin
            donetx_q <= donetx;
            ack      <= '0;
            err      <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        tx_data <= pick_data;
                        gnt_id  <= pick_idx;
                        last    <= pick_idx;
                        send    <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    // The counter saturates, so it cannot wrap and fire a
                    // second timeout.
                    if (cnt != CNT_LAST)
                        cnt <= cnt + 1'b1;
                    // Completion is the rising edge of donetx. A level that
                    // was already high when the frame started does not count.
                    // Completion wins over a timeout in the same cycle.
                    if (donetx && !donetx_q) begin
                        send        <= 1'b0;
                        ack[gnt_id] <= 1'b1;
                        state       <= GAP;
                    end else if (cnt == CNT_LAST) begin
                        send        <= 1'b0;
                        err[gnt_id] <= 1'b1;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    // Wait for donetx to fall. Otherwise a stale high level
                    // could be taken as completion of the next frame.
                    if (!donetx) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    send  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*DW-1:0]      req_data = '0;
    logic [NREQ-1:0]         ack, err;
    logic [$clog2(NREQ)-1:0] gnt_id;
    logic                    busy, send;
    logic [DW-1:0]           tx_data;
    logic                    donetx = 1'b0;

    uart_tx_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .gnt_id(gnt_id), .busy(busy),
        .send(send), .tx_data(tx_data), .donetx(donetx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model. Phase 0 = waiting for a request,
    // 1 = frame in flight, 2 = waiting for donetx to fall.
    int           m_phase = 0;
    bit           m_send = 0, m_busy = 0, m_prev = 0;
    bit [NREQ-1:0] m_ack = '0, m_err = '0;
    int           m_gnt = 0, m_last = NREQ - 1, m_elapsed = 0;
    bit [DW-1:0]  m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_send = 0; m_busy = 0; m_prev = 0;
            m_ack = '0; m_err = '0; m_gnt = 0; m_last = NREQ - 1;
            m_elapsed = 0; m_data = '0;
        end else begin
            m_ack = '0;
            m_err = '0;
            if (m_phase == 0) begin
                bit found;
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    int w;
                    w = (m_last + k) % NREQ;
                    if (!found && req[w]) begin
                        found = 1;
                        m_gnt = w;
                    end
                end
                if (found) begin
                    m_last = m_gnt;
                    m_data = req_data[m_gnt*DW +: DW];
                    m_send = 1; m_busy = 1; m_elapsed = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_elapsed++;
                if (donetx && !m_prev) begin
                    m_ack[m_gnt] = 1; m_send = 0; m_phase = 2;
                end else if (m_elapsed == TO) begin
                    m_err[m_gnt] = 1; m_send = 0; m_phase = 2;
                end
            end else if (!donetx) begin
                m_phase = 0; m_busy = 0;
            end
            m_prev = donetx;
        end
    end

    always @(negedge clk) begin
        chk("send",    int'(send),    int'(m_send));
        chk("busy",    int'(busy),    int'(m_busy));
        chk("ack",     int'(ack),     int'(m_ack));
        chk("err",     int'(err),     int'(m_err));
        chk("gnt_id",  int'(gnt_id),  m_gnt);
        chk("tx_data", int'(tx_data), int'(m_data));
    end

    // Stimulus-side helpers: a small transmitter emulation and requesters
    // that drop req on their own ack/err when enabled in 'drop'.
    int            cyc = 0, lat = 5, scnt = 0, hold_left = 0;
    bit            stuck = 0, prev_send = 0;
    bit [NREQ-1:0] drop = '0;
    int            grants[$];
    int            n_ack = 0, n_err = 0, last_rise = 0, last_ack = 0, last_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (send && !prev_send) begin
            grants.push_back(int'(gnt_id));
            last_rise = cyc;
        end
        prev_send = send;
        if (stuck) begin
            donetx = 1'b0;
            scnt = 0;
        end else if (send) begin
            scnt++;
            if (scnt >= lat) donetx = 1'b1;
        end else begin
            scnt = 0;
            if (hold_left > 0) hold_left--;
            else donetx = 1'b0;
        end
        if (ack != 0) begin n_ack++; last_ack = cyc; end
        if (err != 0) begin n_err++; last_err = cyc; end
        for (int i = 0; i < NREQ; i++)
            if ((ack[i] || err[i]) && drop[i]) req[i] = 1'b0;
    endtask

    task automatic wait_grant(string name, int budget);
        int n0, k;
        n0 = grants.size(); k = 0;
        while (grants.size() == n0 && k < budget) begin tick(); k++; end
        chk({name, "_grant_seen"}, int'(grants.size() > n0), 1);
    endtask

    task automatic wait_ack(string name, int budget);
        int n0, k;
        n0 = n_ack; k = 0;
        while (n_ack == n0 && k < budget) begin tick(); k++; end
        chk({name, "_ack_seen"}, int'(n_ack > n0), 1);
    endtask

    task automatic wait_idle(string name, int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin tick(); k++; end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        int g0, a0, e0;
        bit [DW-1:0] b;
        // Reset held with all requests high.
        req = 4'b1111; drop = '0; lat = 5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_send", int'(send), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ack",  int'(ack),  0);
            chk("rst_err",  int'(err),  0);
        end
        rst = 1'b0;
        wait_grant("rst", 20);
        chk("rst_first_gnt", grants[grants.size()-1], 0);
        req = '0;
        wait_idle("rst", 50);

        // Single request.
        lat = 40; drop = '1;
        b = 8'hA5;
        req_data[2*DW +: DW] = b;
        req = 4'b0100;
        wait_grant("single", 20);
        chk("single_gnt", int'(gnt_id), 2);
        chk("single_data", int'(tx_data), 8'hA5);
        wait_ack("single", 100);
        chk("single_ack_val", int'(ack), 4'b0100);
        chk("single_latency", last_ack - last_rise, 40);
        a0 = n_ack;
        tick();
        chk("single_ack_one_cycle", int'(ack), 0);
        wait_idle("single", 20);
        chk("single_ack_count", n_ack - a0, 0);

        // Round-robin with all four requests held.
        pulse_rst();
        for (int i = 0; i < NREQ; i++) begin
            b = 8'h10 + 8'(i);
            req_data[i*DW +: DW] = b;
        end
        lat = 3; drop = '0; req = 4'b1111;
        g0 = grants.size();
        for (int i = 0; i < 5; i++) wait_grant("rr", 100);
        drop = '1; req = '0;
        wait_idle("rr", 100);
        begin
            int exp_a[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++)
                chk($sformatf("rr_order%0d", i), grants[g0+i], exp_a[i]);
        end
        // Requester 0 asks again only after ack[1] and must queue behind 2 and 3.
        pulse_rst();
        g0 = grants.size();
        req = 4'b1110;
        wait_ack("rr_b", 100);
        chk("rr_b_ack1", int'(ack), 4'b0010);
        req[0] = 1'b1;
        for (int i = 0; i < 3; i++) wait_grant("rr_b", 100);
        wait_idle("rr_b", 100);
        begin
            int exp_b[4] = '{1, 2, 3, 0};
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr_b_order%0d", i), grants[g0+i], exp_b[i]);
        end

        // Timeout with the transmitter stuck.
        stuck = 1; a0 = n_ack; e0 = n_err;
        req = 4'b1000;
        wait_grant("to", 20);
        begin
            int k;
            k = 0;
            while (n_err == e0 && k < 300) begin tick(); k++; end
        end
        chk("to_err_seen", n_err - e0, 1);
        chk("to_err_val", int'(err), 4'b1000);
        chk("to_delay", last_err - last_rise, TO);
        chk("to_send_low", int'(send), 0);
        wait_idle("to", 20);
        chk("to_no_ack", n_ack - a0, 0);
        stuck = 0;

        // Stale donetx level held through GAP with a pending request.
        lat = 10; a0 = n_ack;
        req = 4'b0010;
        wait_grant("stale", 20);
        hold_left = 20;
        wait_ack("stale", 50);
        req[1] = 1'b1;
        g0 = grants.size();
        wait_grant("stale2", 60);
        chk("stale_gap", last_rise - last_ack, 22);
        chk("stale_no_spurious", n_ack - a0, 1);
        wait_ack("stale2", 50);
        wait_idle("stale", 20);
        chk("stale_ack_total", n_ack - a0, 2);

        // Reset in the middle of SEND.
        stuck = 1; drop = '0; a0 = n_ack; e0 = n_err;
        req = 4'b0101;
        wait_grant("mid", 20);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_send_low", int'(send), 0);
        chk("mid_ack", int'(ack), 0);
        chk("mid_err", int'(err), 0);
        rst = 1'b0;
        wait_grant("mid2", 20);
        chk("mid_regrant", grants[grants.size()-1], 0);
        chk("mid_no_resp", (n_ack - a0) + (n_err - e0), 0);
        stuck = 0; lat = 3; drop = '1; req = '0;
        wait_idle("mid", 50);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
